// File: rtl/idu_pkg.sv
// Shared definitions for the IDU receive slice.
// Contents:
//   inst_class_t - RV32I opcode class reported to the EXU
//   buf_state_t  - occupancy of the two-entry fetch skid buffer
//   OPC_*        - RV32I major opcodes (inst[6:0])
//   *_LSB        - bit offsets of register fields and of the pc inside a fetch packet
package idu_pkg;

    typedef enum logic [3:0] {
        IC_LUI,
        IC_AUIPC,
        IC_JAL,
        IC_JALR,
        IC_BRANCH,
        IC_LOAD,
        IC_STORE,
        IC_OPIMM,
        IC_OP,
        IC_FENCE,
        IC_SYSTEM,
        IC_ILLEGAL
    } inst_class_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } buf_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int REG_W   = 5;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // Fetch packet layout: {inst, pc}; pc occupies the low WIDTH bits and
    // inst the WIDTH bits directly above it.
    localparam int PKT_PC_LSB = 0;

endpackage

// File: rtl/rv32_decode.sv
// Pure combinational RV32I pre-decoder.
// Ports:
//   inst    - raw instruction word
//   cls     - opcode class (IC_ILLEGAL for unknown opcodes or inst[1:0] != 2'b11)
//   rd      - destination register, forced to 0 for classes that write no register
//   rs1/rs2 - source register fields, passed through unconditionally
//   imm     - sign-extended immediate for the class's format, 0 for OP and ILLEGAL
//   illegal - cls == IC_ILLEGAL
module rv32_decode
    import idu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    [WIDTH-1:0] inst,
    output inst_class_t                         cls,
    output logic                    [REG_W-1:0] rd,
    output logic                    [REG_W-1:0] rs1,
    output logic                    [REG_W-1:0] rs2,
    output logic signed             [WIDTH-1:0] imm,
    output logic                                illegal
);

    function automatic logic signed [WIDTH-1:0] imm_i(input logic [WIDTH-1:0] i);
        return {{(WIDTH-11){i[31]}}, i[30:20]};
    endfunction

    function automatic logic signed [WIDTH-1:0] imm_s(input logic [WIDTH-1:0] i);
        return {{(WIDTH-11){i[31]}}, i[30:25], i[11:7]};
    endfunction

    function automatic logic signed [WIDTH-1:0] imm_b(input logic [WIDTH-1:0] i);
        return {{(WIDTH-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic signed [WIDTH-1:0] imm_u(input logic [WIDTH-1:0] i);
        return {{(WIDTH-31){i[31]}}, i[30:12], 12'b0};
    endfunction

    function automatic logic signed [WIDTH-1:0] imm_j(input logic [WIDTH-1:0] i);
        return {{(WIDTH-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    always_comb begin
        cls = IC_ILLEGAL;
        // Compressed / non-32-bit encodings are not supported by this core.
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPC_LUI:    cls = IC_LUI;
                OPC_AUIPC:  cls = IC_AUIPC;
                OPC_JAL:    cls = IC_JAL;
                OPC_JALR:   cls = IC_JALR;
                OPC_BRANCH: cls = IC_BRANCH;
                OPC_LOAD:   cls = IC_LOAD;
                OPC_STORE:  cls = IC_STORE;
                OPC_OPIMM:  cls = IC_OPIMM;
                OPC_OP:     cls = IC_OP;
                OPC_FENCE:  cls = IC_FENCE;
                OPC_SYSTEM: cls = IC_SYSTEM;
                default:    cls = IC_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        rs1 = inst[RS1_LSB +: REG_W];
        rs2 = inst[RS2_LSB +: REG_W];
        rd  = inst[RD_LSB +: REG_W];
        imm = '0;
        case (cls)
            IC_LUI, IC_AUIPC:                          imm = imm_u(inst);
            IC_JAL:                                    imm = imm_j(inst);
            IC_JALR, IC_LOAD, IC_OPIMM, IC_SYSTEM,
            IC_FENCE:                                  imm = imm_i(inst);
            IC_BRANCH:                                 imm = imm_b(inst);
            IC_STORE:                                  imm = imm_s(inst);
            default:                                   imm = '0;
        endcase
        // inst[11:7] carries immediate bits (or nothing) for these classes.
        if (cls == IC_STORE || cls == IC_BRANCH || cls == IC_FENCE || cls == IC_ILLEGAL)
            rd = '0;
        illegal = (cls == IC_ILLEGAL);
    end

endmodule

// File: rtl/idu_rx.sv
// Receiving end of the IFU->IDU fetch interface.
// A two-entry skid buffer (head + skid) lets idu_ready be a register while
// still sustaining one packet per cycle. The head entry is decoded and offered
// to the EXU on its own valid/ready handshake. flush empties the buffer.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   ifu_valid/data  - incoming {inst, pc} packet, idu_ready back-pressures it
//   flush           - drop everything buffered plus any packet arriving this cycle
//   exu_valid/ready - head-entry handshake towards the EXU
//   exu_*           - head pc, raw inst and its decode; all 0 while exu_valid=0
module idu_rx
    import idu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DATA_W = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_valid,
    input  logic [DATA_W-1:0] ifu_data,
    output logic              idu_ready,
    input  logic              flush,
    output logic              exu_valid,
    input  logic              exu_ready,
    output logic [WIDTH-1:0]  exu_pc,
    output logic [WIDTH-1:0]  exu_inst,
    output inst_class_t       exu_class,
    output logic [REG_W-1:0]  exu_rd,
    output logic [REG_W-1:0]  exu_rs1,
    output logic [REG_W-1:0]  exu_rs2,
    output logic [WIDTH-1:0]  exu_imm,
    output logic              exu_illegal
);

    buf_state_t        state_p0;
    buf_state_t        state_nxt;
    logic [DATA_W-1:0] head_p0;
    logic [DATA_W-1:0] skid_p0;
    logic              rdy_p0;
    logic              vld_p0;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = ifu_valid & rdy_p0;
    assign out_fire = vld_p0 & exu_ready;

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_EMPTY: if (in_fire) state_nxt = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_nxt = ST_FULL;
                else if (!in_fire && out_fire) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (out_fire) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush)
            state_nxt = ST_EMPTY;
    end

    // ---- stage p0: skid buffer registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ST_EMPTY;
            rdy_p0   <= 1'b0;
            vld_p0   <= 1'b0;
            head_p0  <= '0;
            skid_p0  <= '0;
        end else begin
            state_p0 <= state_nxt;
            // Both flags come from next-state so neither depends combinationally
            // on exu_ready at the interface.
            rdy_p0   <= (state_nxt != ST_FULL);
            vld_p0   <= (state_nxt != ST_EMPTY);
            // Data moves are harmless under flush: vld_p0 drops and gates them.
            case (state_p0)
                ST_EMPTY: if (in_fire) head_p0 <= ifu_data;
                ST_ONE: begin
                    if (in_fire && out_fire) head_p0 <= ifu_data;
                    else if (in_fire)        skid_p0 <= ifu_data;
                end
                ST_FULL:  if (out_fire) head_p0 <= skid_p0;
                default: ;
            endcase
        end
    end

    // ---- head decode and EXU presentation ----
    inst_class_t              dec_cls;
    logic [REG_W-1:0]         dec_rd;
    logic [REG_W-1:0]         dec_rs1;
    logic [REG_W-1:0]         dec_rs2;
    logic signed [WIDTH-1:0]  dec_imm;
    logic                     dec_ill;

    rv32_decode #(.WIDTH(WIDTH)) u_dec (
        .inst    (head_p0[WIDTH +: WIDTH]),
        .cls     (dec_cls),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign idu_ready = rdy_p0;
    assign exu_valid = vld_p0;

    always_comb begin
        exu_pc      = '0;
        exu_inst    = '0;
        exu_class   = inst_class_t'(4'd0);
        exu_rd      = '0;
        exu_rs1     = '0;
        exu_rs2     = '0;
        exu_imm     = '0;
        exu_illegal = 1'b0;
        if (vld_p0) begin
            exu_pc      = head_p0[PKT_PC_LSB +: WIDTH];
            exu_inst    = head_p0[WIDTH +: WIDTH];
            exu_class   = dec_cls;
            exu_rd      = dec_rd;
            exu_rs1     = dec_rs1;
            exu_rs2     = dec_rs2;
            exu_imm     = dec_imm;
            exu_illegal = dec_ill;
        end
    end

endmodule

// File: tb/tb_idu_rx.sv
// Bench for idu_rx: directed scenarios followed by randomized traffic; an input
// monitor pushes expected decoded packets, an output monitor pops and compares.
module tb_idu_rx;
    import idu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ifu_valid = 1'b0;
    logic [DATA_W-1:0] ifu_data = '0;
    logic              idu_ready;
    logic              flush = 1'b0;
    logic              exu_valid;
    logic              exu_ready = 1'b0;
    logic [WIDTH-1:0]  exu_pc;
    logic [WIDTH-1:0]  exu_inst;
    inst_class_t       exu_class;
    logic [4:0]        exu_rd;
    logic [4:0]        exu_rs1;
    logic [4:0]        exu_rs2;
    logic [WIDTH-1:0]  exu_imm;
    logic              exu_illegal;

    idu_rx #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_valid   (ifu_valid),
        .ifu_data    (ifu_data),
        .idu_ready   (idu_ready),
        .flush       (flush),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_pc      (exu_pc),
        .exu_inst    (exu_inst),
        .exu_class   (exu_class),
        .exu_rd      (exu_rd),
        .exu_rs1     (exu_rs1),
        .exu_rs2     (exu_rs2),
        .exu_imm     (exu_imm),
        .exu_illegal (exu_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        inst_class_t cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } pkt_t;

    pkt_t q[$];
    bit   exp_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference decode written from the instruction-format tables.
    function automatic pkt_t ref_model(input logic [31:0] inst, input logic [31:0] pc);
        pkt_t        r;
        logic [31:0] u;
        logic [31:0] sx;
        u  = inst;
        sx = {32{inst[31]}};
        r.pc  = pc;
        r.inst = inst;
        r.rs1 = inst[19:15];
        r.rs2 = inst[24:20];
        r.cls = IC_ILLEGAL;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                7'h37: r.cls = IC_LUI;
                7'h17: r.cls = IC_AUIPC;
                7'h6F: r.cls = IC_JAL;
                7'h67: r.cls = IC_JALR;
                7'h63: r.cls = IC_BRANCH;
                7'h03: r.cls = IC_LOAD;
                7'h23: r.cls = IC_STORE;
                7'h13: r.cls = IC_OPIMM;
                7'h33: r.cls = IC_OP;
                7'h0F: r.cls = IC_FENCE;
                7'h73: r.cls = IC_SYSTEM;
                default: r.cls = IC_ILLEGAL;
            endcase
        end
        case (r.cls)
            IC_LUI, IC_AUIPC: r.imm = u & 32'hFFFFF000;
            IC_JAL: r.imm = (sx << 20) | (u & 32'h000FF000) | (((u >> 20) & 32'h1) << 11)
                            | (((u >> 21) & 32'h3FF) << 1);
            IC_BRANCH: r.imm = (sx << 12) | (((u >> 7) & 32'h1) << 11)
                               | (((u >> 25) & 32'h3F) << 5) | (((u >> 8) & 32'hF) << 1);
            IC_STORE: r.imm = (sx << 11) | (((u >> 25) & 32'h3F) << 5) | ((u >> 7) & 32'h1F);
            IC_JALR, IC_LOAD, IC_OPIMM, IC_SYSTEM, IC_FENCE: r.imm = (sx << 11) | (u >> 20);
            default: r.imm = 32'h0;
        endcase
        if (r.cls == IC_STORE || r.cls == IC_BRANCH || r.cls == IC_FENCE || r.cls == IC_ILLEGAL)
            r.rd = 5'd0;
        else
            r.rd = inst[11:7];
        r.ill = (r.cls == IC_ILLEGAL);
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 12))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            11: w[1:0] = 2'b01;
            default: ;
        endcase
        return w;
    endfunction

    // Output monitor: compares the head against the scoreboard, pops on accept.
    initial begin
        pkt_t a;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rst_exu_valid", exu_valid, 0);
                chk("rst_idu_ready", idu_ready, 0);
                q.delete();
            end else begin
                chk("exu_valid", exu_valid, q.size() != 0);
                chk("idu_ready", idu_ready, exp_ready);
                if (q.size() != 0) begin
                    a.pc = exu_pc;   a.inst = exu_inst; a.cls = exu_class;
                    a.rd = exu_rd;   a.rs1 = exu_rs1;   a.rs2 = exu_rs2;
                    a.imm = exu_imm; a.ill = exu_illegal;
                    chk("packet", a, q[0]);
                    if (exu_ready)
                        void'(q.pop_front());
                end
            end
        end
    end

    // Input monitor: pushes expected packets on accept, applies flush/reset.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                q.delete();
                exp_ready = 1'b0;
            end else if (flush) begin
                q.delete();
                exp_ready = 1'b1;
            end else begin
                if (ifu_valid && exp_ready)
                    q.push_back(ref_model(ifu_data[63:32], ifu_data[31:0]));
                exp_ready = (q.size() != 2);
            end
        end
    end

    // Present a packet and hold it until accepted; returns on the negedge after acceptance.
    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        int n;
        n = 0;
        ifu_valid = 1'b1;
        ifu_data  = {inst, pc};
        while (!idu_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            chk("send_timeout", 1, 0);
        @(negedge clk);
        ifu_valid = 1'b0;
    endtask

    task automatic drain();
        exu_ready = 1'b1;
        repeat (3) @(negedge clk);
        exu_ready = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        chk("in_rst_ready", idu_ready, 0);
        chk("in_rst_valid", exu_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", idu_ready, 1);
        chk("post_rst_valid", exu_valid, 0);
        chk("post_rst_imm", exu_imm, 0);

        // Single addi
        exu_ready = 1'b1;
        send(32'h00500093, 32'h80000000);
        chk("addi_valid", exu_valid, 1);
        chk("addi_class", exu_class, IC_OPIMM);
        chk("addi_rd", exu_rd, 1);
        chk("addi_rs1", exu_rs1, 0);
        chk("addi_imm", exu_imm, 32'd5);
        chk("addi_pc", exu_pc, 32'h80000000);
        @(negedge clk);

        // Backpressure with three packets
        exu_ready = 1'b0;
        send(32'h00100113, 32'h100);
        send(32'h00200193, 32'h104);
        chk("bp_ready_low", idu_ready, 0);
        fork
            send(32'h00300213, 32'h108);
            begin
                repeat (3) @(negedge clk);
                chk("bp_hold_ready", idu_ready, 0);
                exu_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Streaming
        exu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_ready", idu_ready, 1);
            send(32'h00A00513 + (i << 20), i * 4);
            chk("stream_valid", exu_valid, 1);
        end
        drain();

        // Immediate formats
        send(32'hFE20AE23, 32'h200);
        chk("sw_class", exu_class, IC_STORE);
        chk("sw_imm", exu_imm, 32'hFFFFFFFC);
        chk("sw_rd", exu_rd, 0);
        drain();
        send(32'hFE000CE3, 32'h204);
        chk("beq_class", exu_class, IC_BRANCH);
        chk("beq_imm", exu_imm, 32'hFFFFFFF8);
        drain();
        send(32'h001000EF, 32'h208);
        chk("jal_class", exu_class, IC_JAL);
        chk("jal_imm", exu_imm, 32'h00000800);
        drain();
        send(32'h00000000, 32'h20C);
        chk("zero_class", exu_class, IC_ILLEGAL);
        chk("zero_illegal", exu_illegal, 1);
        drain();

        // Flush with FULL buffer and simultaneous incoming packet
        send(32'h00100093, 32'h300);
        send(32'h00200093, 32'h304);
        ifu_valid = 1'b1;
        ifu_data  = {32'h0DEAD037, 32'h308};
        flush     = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        ifu_valid = 1'b0;
        chk("flush_valid", exu_valid, 0);
        chk("flush_ready", idu_ready, 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset with a packet buffered; IFU re-presents it afterwards
        send(32'h00400093, 32'h400);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", exu_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exu_ready = 1'b1;
        send(32'h00400093, 32'h400);
        @(negedge clk);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!(ifu_valid && !idu_ready && !flush)) begin
                ifu_valid = ($urandom_range(0, 3) != 0);
                ifu_data  = {rand_inst(), $urandom()};
            end
            exu_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            if (c == 2200) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_async_rst", exu_valid, 0);
                @(negedge clk);
                rst_n = 1'b1;
                flush = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        ifu_valid = 1'b0;
        flush     = 1'b0;
        exu_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("final_empty", exu_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
